// File: rtl/fifo_stream_pkg.sv
// Shared constants and elaboration helpers for the FIFO stream reader.
// Latency: n/a (package only).
// Backpressure: n/a.
package fifo_stream_pkg;

    localparam int MAX_READ_LATENCY = 3;

    // Bits needed to hold any value 0..n.
    function automatic int clog2_count(input int n);
        return $clog2(n + 1);
    endfunction

    // The buffer must absorb every in-flight word plus one being popped.
    function automatic bit buf_fits_latency(input int log_buf, input int read_latency);
        return (2 ** log_buf) >= (read_latency + 1);
    endfunction

endpackage

// File: rtl/latency_valid_pipe.sv
// Tracks which issued FIFO reads are still travelling toward fifo_q.
// Latency: DEPTH cycles from issue to the last stage.
// Backpressure: none; the issuer must only issue when credit is available.
module latency_valid_pipe
    import fifo_stream_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = clog2_count(DEPTH)
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             issue,
    output logic [DEPTH-1:0] stages,
    output logic [CW-1:0]    inflight
);

    logic [DEPTH-1:0] next_stages;

    generate
        if (DEPTH == 1) begin : g_single
            assign next_stages = issue;
        end else begin : g_multi
            assign next_stages = {stages[DEPTH-2:0], issue};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (sclr) begin
            stages <= '0;
        end else begin
            stages <= next_stages;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight = inflight + CW'(stages[i]);
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a normal-mode FIFO and re-presents its words as a valid/ready stream.
// Latency: first out_valid READ_LATENCY+1 cycles after the first fifo_rdreq; 1 word/cycle steady state.
// Backpressure: reads are issued only while buffered + in-flight words fit in the prefetch buffer.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH        = 20,
    parameter int READ_LATENCY = 2,
    parameter int LOG_BUF      = 2
) (
    input  logic               clock,
    input  logic               sclr,
    input  logic               fifo_rdempty,
    output logic               fifo_rdreq,
    input  logic [WIDTH-1:0]   fifo_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [LOG_BUF:0]   out_count
);

    localparam int BUF = 2 ** LOG_BUF;
    localparam int NW  = LOG_BUF + 1;
    localparam int IW  = clog2_count(READ_LATENCY);
    localparam int CW  = LOG_BUF + 2;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
            !buf_fits_latency(LOG_BUF, READ_LATENCY)) begin : g_bad_params
            $error("fifo_stream_reader: READ_LATENCY must be 1..3 and 2**LOG_BUF >= READ_LATENCY+1");
        end
    endgenerate

    logic [READ_LATENCY-1:0] lat_stages;
    logic [IW-1:0]           inflight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [CW-1:0]           credits_used;
    logic [LOG_BUF-1:0]      wr_ptr;
    logic [LOG_BUF-1:0]      rd_ptr;
    logic [WIDTH-1:0]        buf_mem [BUF];

    latency_valid_pipe #(
        .DEPTH (READ_LATENCY),
        .CW    (IW)
    ) u_lat_pipe (
        .clock    (clock),
        .sclr     (sclr),
        .issue    (issue),
        .stages   (lat_stages),
        .inflight (inflight)
    );

    // A pop this cycle frees a slot immediately, so issue resumes with no bubble.
    assign pop          = out_valid & out_ready;
    assign push         = lat_stages[READ_LATENCY-1];
    assign credits_used = CW'(out_count) + CW'(inflight) - CW'(pop);
    assign issue        = ~fifo_rdempty & ~sclr & (credits_used < CW'(BUF));
    assign fifo_rdreq   = issue;

    assign out_valid = (out_count != '0);
    assign out_data  = buf_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            out_count <= out_count + NW'(push) - NW'(pop);
        end
    end

    // Storage needs no reset: out_count alone decides what is readable.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_mem[wr_ptr] <= fifo_q;
        end
    end

    assert property (@(posedge clock) disable iff (sclr) push |-> (out_count < NW'(BUF)));
    assert property (@(posedge clock) disable iff (sclr) $countones(lat_stages) == 32'(inflight));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Drives three readers (READ_LATENCY 1, 2, 3) from behavioural normal-mode FIFOs.
// Expected words are queued at FIFO write time and popped on every output handshake.
module tb_fifo_stream_reader;

    localparam int W = 20;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         sclr       = 1'b1;
    logic         fifo_clr   = 1'b1;
    logic         hold_empty = 1'b0;
    logic         wr_en      = 1'b0;
    logic [W-1:0] wr_data    = '0;
    logic         out_ready  = 1'b0;
    logic         stat_clr   = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int t0    = 0;

    wire        w_rdreq [N];
    wire        w_vld   [N];
    wire [2:0]  w_cnt   [N];
    wire [31:0] st_first_req [N];
    wire [31:0] st_first_vld [N];
    wire [31:0] st_first_hs  [N];
    wire [31:0] st_last_hs   [N];
    wire [31:0] st_n_hs      [N];
    wire [31:0] st_n_req     [N];
    wire [31:0] st_max_cnt   [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    generate
        for (genvar g = 0; g < N; g++) begin : g_i
            localparam int RL = g + 1;

            logic         rdempty, rdreq, vld;
            logic [W-1:0] q, data;
            logic [2:0]   cnt;
            logic         fempty = 1'b1;
            logic [W-1:0] qp [RL];
            logic [W-1:0] fq [$];
            logic [W-1:0] exp_q [$];
            int first_req = -1, first_vld = -1, first_hs = -1, last_hs = -1;
            int n_hs = 0, n_req = 0, max_cnt = 0;

            assign rdempty = fempty | hold_empty;
            assign q       = qp[RL-1];

            fifo_stream_reader #(
                .WIDTH        (W),
                .READ_LATENCY (RL),
                .LOG_BUF      (2)
            ) dut (
                .clock        (clk),
                .sclr         (sclr),
                .fifo_rdempty (rdempty),
                .fifo_rdreq   (rdreq),
                .fifo_q       (q),
                .out_valid    (vld),
                .out_ready    (out_ready),
                .out_data     (data),
                .out_count    (cnt)
            );

            // Normal-mode FIFO: a read at this edge shows on q RL cycles later.
            always @(posedge clk) begin : fifo_model
                logic [W-1:0] rd_w;
                if (fifo_clr) begin
                    fq.delete();
                    exp_q.delete();
                    for (int i = 0; i < RL; i++) qp[i] <= '0;
                end else begin
                    rd_w = 20'hEEEEE;
                    if (rdreq) begin
                        chk($sformatf("g%0d_underflow", g), 32'(fq.size() != 0), 32'd1);
                        if (fq.size() != 0) rd_w = fq.pop_front();
                    end
                    qp[0] <= rd_w;
                    for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
                    if (wr_en) begin
                        fq.push_back(wr_data);
                        exp_q.push_back(wr_data);
                    end
                end
                fempty <= (fq.size() == 0);
            end

            always @(negedge clk) begin : monitor
                logic [W-1:0] e;
                if (stat_clr) begin
                    first_req = -1; first_vld = -1; first_hs = -1; last_hs = -1;
                    n_hs = 0; n_req = 0; max_cnt = 0;
                end else begin
                    if (rdreq) begin
                        n_req++;
                        if (first_req < 0) first_req = cyc;
                    end
                    if (vld && first_vld < 0) first_vld = cyc;
                    if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
                    if (vld && out_ready) begin
                        n_hs++;
                        if (first_hs < 0) first_hs = cyc;
                        last_hs = cyc;
                    end
                end
                if (vld && out_ready) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                    chk($sformatf("g%0d_order", g), 32'(data), 32'(e));
                end
            end

            assign w_rdreq[g]      = rdreq;
            assign w_vld[g]        = vld;
            assign w_cnt[g]        = cnt;
            assign st_first_req[g] = first_req;
            assign st_first_vld[g] = first_vld;
            assign st_first_hs[g]  = first_hs;
            assign st_last_hs[g]   = last_hs;
            assign st_n_hs[g]      = n_hs;
            assign st_n_req[g]     = n_req;
            assign st_max_cnt[g]   = max_cnt;
        end
    endgenerate

    initial begin
        // Reset with a non-empty FIFO: no reads may be issued.
        tick(1);
        fifo_clr = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = W'(i); tick(1);
        end
        wr_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                chk($sformatf("g%0d_rst_rdreq", g), 32'(w_rdreq[g]), 32'd0);
                chk($sformatf("g%0d_rst_vld", g), 32'(w_vld[g]), 32'd0);
                chk($sformatf("g%0d_rst_cnt", g), 32'(w_cnt[g]), 32'd0);
            end
            tick(1);
        end

        // Streaming 16 preloaded words with out_ready held high.
        sclr = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < N; g++)
            chk($sformatf("g%0d_first_rdreq", g), 32'(w_rdreq[g]), 32'd1);
        tick(30);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("g%0d_latency", g), st_first_vld[g] - st_first_req[g], 32'(g + 2));
            chk($sformatf("g%0d_stream_n", g), st_n_hs[g], 32'd16);
            chk($sformatf("g%0d_stream_span", g), st_last_hs[g] - st_first_hs[g], 32'd15);
            chk($sformatf("g%0d_stream_start", g), st_first_hs[g], st_first_vld[g]);
        end
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("g%0d_drained_vld", g), 32'(w_vld[g]), 32'd0);
            chk($sformatf("g%0d_drained_cnt", g), 32'(w_cnt[g]), 32'd0);
        end
        tick(1);

        // Backpressure: 10 words available, out_ready low.
        out_ready = 1'b0; hold_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = W'(32'h20000 + i); tick(1);
        end
        wr_en = 1'b0; stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0; hold_empty = 1'b0;
        tick(12);
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("g%0d_bp_nreq", g), st_n_req[g], 32'd4);
            chk($sformatf("g%0d_bp_cnt", g), 32'(w_cnt[g]), 32'd4);
            chk($sformatf("g%0d_bp_rdreq", g), 32'(w_rdreq[g]), 32'd0);
        end
        tick(1);
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0; out_ready = 1'b1; t0 = cyc;
        tick(20);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("g%0d_resume_first", g), st_first_hs[g], 32'(t0));
            chk($sformatf("g%0d_resume_n", g), st_n_hs[g], 32'd10);
            chk($sformatf("g%0d_resume_span", g), st_last_hs[g] - st_first_hs[g], 32'd9);
            chk($sformatf("g%0d_resume_nreq", g), st_n_req[g], 32'd6);
        end

        // Bursty empty with random backpressure.
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        for (int k = 0; k < 60; k++) begin
            hold_empty = ((k / 2) % 2) == 1;
            out_ready  = 1'($urandom_range(0, 1));
            wr_en      = (k < 30);
            wr_data    = W'(32'h30000 + k);
            tick(1);
        end
        wr_en = 1'b0; hold_empty = 1'b0; out_ready = 1'b1;
        tick(50);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("g%0d_burst_n", g), st_n_hs[g], 32'd30);
            chk($sformatf("g%0d_burst_max_le4", g), 32'(st_max_cnt[g] <= 32'd4), 32'd1);
        end

        // Reset while words are in flight and buffered.
        out_ready = 1'b0; hold_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = W'(32'h40000 + i); tick(1);
        end
        wr_en = 1'b0; hold_empty = 1'b0;
        tick(3);
        sclr = 1'b1; fifo_clr = 1'b1; stat_clr = 1'b1;
        @(negedge clk);
        chk("g1_pre_rst_cnt", 32'(w_cnt[1]), 32'd1);
        tick(1);
        sclr = 1'b0; fifo_clr = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("g%0d_midrst_cnt", g), 32'(w_cnt[g]), 32'd0);
            chk($sformatf("g%0d_midrst_vld", g), 32'(w_vld[g]), 32'd0);
        end
        repeat (5) begin
            tick(1);
            @(negedge clk);
            for (int g = 0; g < N; g++)
                chk($sformatf("g%0d_no_stale_vld", g), 32'(w_vld[g]), 32'd0);
        end
        tick(1);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = W'(32'h50000 + i); tick(1);
        end
        wr_en = 1'b0;
        tick(20);
        for (int g = 0; g < N; g++)
            chk($sformatf("g%0d_post_rst_n", g), st_n_hs[g], 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
